// File: rtl/fetch_sequencer_if.sv
// Bundle of signals between the fetch sequencer and its surroundings:
// instruction memory, datapath compare/register results, user input and status.
interface fetch_sequencer_if;
  logic [31:0] Instruction;
  logic        BranchTaken;
  logic [31:0] RegisterValue;
  logic        InputReady;
  logic [31:0] ProgramCounter;
  logic        InstructionValid;
  logic        WaitingInput;
  logic        Halted;
  logic        AddressFault;
  logic [31:0] RetiredCount;

  modport master (
    input  Instruction, BranchTaken, RegisterValue, InputReady,
    output ProgramCounter, InstructionValid, WaitingInput, Halted, AddressFault, RetiredCount
  );

  modport slave (
    output Instruction, BranchTaken, RegisterValue, InputReady,
    input  ProgramCounter, InstructionValid, WaitingInput, Halted, AddressFault, RetiredCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC / fetch-control stage: drives the word address into a registered-read
// instruction memory and picks the next PC from the returned opcode.
module fetch_sequencer #(
  parameter int unsigned MEM_DEPTH = 100
) (
  input  logic               Clock,
  input  logic               Reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    WAIT_IN = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam logic [5:0]  OP_HALT = 6'b000001;
  localparam logic [5:0]  OP_J    = 6'b001110;
  localparam logic [5:0]  OP_JR   = 6'b001101;
  localparam logic [5:0]  OP_BEQ  = 6'b010000;
  localparam logic [5:0]  OP_BNE  = 6'b010001;
  localparam logic [5:0]  OP_IN   = 6'b001011;
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        fault_q, fault_d;

  logic [5:0]  opcode;
  logic [31:0] pc_inc;
  logic [31:0] exec_target;
  logic [31:0] next_pc;
  logic        advance;
  logic        retire;

  // Target chosen by the opcode currently in EXEC; anything unrecognised is sequential.
  always_comb begin
    opcode      = bus.Instruction[31:26];
    pc_inc      = pc_q + 32'd1;
    exec_target = pc_inc;
    case (opcode)
      OP_J:           exec_target = {6'b0, bus.Instruction[25:0]};
      OP_JR:          exec_target = bus.RegisterValue;
      OP_BEQ, OP_BNE: if (bus.BranchTaken) exec_target = {16'b0, bus.Instruction[15:0]};
      default:        exec_target = pc_inc;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    next_pc   = pc_inc;
    advance   = 1'b0;
    retire    = 1'b0;

    case (state_q)
      FETCH: state_d = EXEC;
      EXEC: begin
        if (opcode == OP_HALT) begin
          state_d = HALT;
          retire  = 1'b1;
        end else if ((opcode == OP_IN) && !bus.InputReady) begin
          state_d = WAIT_IN;
        end else begin
          advance = 1'b1;
          next_pc = exec_target;
        end
      end
      WAIT_IN: begin
        if (bus.InputReady) begin
          advance = 1'b1;
          next_pc = pc_inc;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase

    // An out-of-range target leaves the PC on the faulting instruction.
    if (advance) begin
      retire = 1'b1;
      if (next_pc >= DEPTH_W) begin
        fault_d = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = next_pc;
        state_d = FETCH;
      end
    end

    if (retire && (retired_q != 32'hFFFF_FFFF)) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= FETCH;
      pc_q      <= 32'd0;
      retired_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  assign bus.ProgramCounter   = pc_q;
  assign bus.RetiredCount     = retired_q;
  assign bus.AddressFault     = fault_q;
  assign bus.InstructionValid = (state_q == EXEC);
  assign bus.WaitingInput     = (state_q == WAIT_IN);
  assign bus.Halted           = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed program walk followed by random programs,
// checked against an instruction-level model of where the PC must go next.
module tb_fetch_sequencer;
  localparam int unsigned DEPTH = 100;

  logic Clock;
  logic Reset;
  fetch_sequencer_if bus ();

  fetch_sequencer #(.MEM_DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [31:0] mem [DEPTH];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_fault;
  logic        m_halted;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Registered-read instruction memory
  always @(posedge Clock) begin
    if (bus.ProgramCounter < DEPTH) bus.Instruction <= mem[bus.ProgramCounter[6:0]];
    else                            bus.Instruction <= 32'h0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_inputs();
    bus.InputReady    = 1'($urandom_range(0, 1));
    bus.BranchTaken   = 1'($urandom_range(0, 1));
    bus.RegisterValue = $urandom;
  endtask

  task automatic do_reset();
    Reset             = 1'b1;
    randomize_inputs();
    @(negedge Clock);
    Reset    = 1'b0;
    m_pc     = 32'd0;
    m_ret    = 32'd0;
    m_fault  = 1'b0;
    m_halted = 1'b0;
    check_eq("rst_pc",     bus.ProgramCounter,           32'd0);
    check_eq("rst_valid",  32'(bus.InstructionValid),    32'd0);
    check_eq("rst_wait",   32'(bus.WaitingInput),        32'd0);
    check_eq("rst_halted", 32'(bus.Halted),              32'd0);
    check_eq("rst_fault",  32'(bus.AddressFault),        32'd0);
    check_eq("rst_ret",    bus.RetiredCount,             32'd0);
    $display("reset pc=%0d", bus.ProgramCounter);
  endtask

  // Walks one instruction: entered at the negedge of its FETCH cycle, leaves at
  // the negedge of the following FETCH (or first HALT) cycle.
  task automatic do_instr(input bit bt, input logic [31:0] rv, input bit ir, input int wait_n);
    logic [31:0] ins;
    logic [31:0] old_pc;
    logic [5:0]  op;
    logic [32:0] nxt;
    bit          moves;
    int          waits;
    old_pc = m_pc;
    waits  = 0;
    check_eq("fetch_pc",     bus.ProgramCounter,        m_pc);
    check_eq("fetch_valid",  32'(bus.InstructionValid), 32'd0);
    check_eq("fetch_halted", 32'(bus.Halted),           32'd0);
    randomize_inputs();
    @(negedge Clock);
    check_eq("exec_valid", 32'(bus.InstructionValid), 32'd1);
    check_eq("exec_pc",    bus.ProgramCounter,        m_pc);
    check_eq("exec_wait",  32'(bus.WaitingInput),     32'd0);
    ins               = mem[m_pc[6:0]];
    op                = ins[31:26];
    bus.BranchTaken   = bt;
    bus.RegisterValue = rv;
    bus.InputReady    = ir;
    moves             = 1'b1;
    nxt               = {1'b0, m_pc} + 33'd1;
    case (op)
      6'b000001: begin
        moves    = 1'b0;
        m_halted = 1'b1;
      end
      6'b001110:          nxt = {7'b0, ins[25:0]};
      6'b001101:          nxt = {1'b0, rv};
      6'b010000, 6'b010001: if (bt) nxt = {17'b0, ins[15:0]};
      6'b001011: begin
        if (!ir) begin
          waits = (wait_n < 1) ? 1 : wait_n;
          for (int k = 0; k < waits; k++) begin
            @(negedge Clock);
            check_eq("wait_flag",  32'(bus.WaitingInput),     32'd1);
            check_eq("wait_valid", 32'(bus.InstructionValid), 32'd0);
            check_eq("wait_pc",    bus.ProgramCounter,        m_pc);
            check_eq("wait_ret",   bus.RetiredCount,          m_ret);
            bus.InputReady    = (k == waits - 1);
            bus.BranchTaken   = 1'($urandom_range(0, 1));
            bus.RegisterValue = $urandom;
          end
        end
      end
      default: ;
    endcase
    if (moves) begin
      if (nxt >= 33'(DEPTH)) begin
        m_fault  = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc = nxt[31:0];
      end
    end
    if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
    @(negedge Clock);
    check_eq("post_pc",     bus.ProgramCounter,    m_pc);
    check_eq("post_ret",    bus.RetiredCount,      m_ret);
    check_eq("post_fault",  32'(bus.AddressFault), 32'(m_fault));
    check_eq("post_halted", 32'(bus.Halted),       32'(m_halted));
    $display("instr pc=%0d word=%08h waits=%0d -> pc=%0d ret=%0d halted=%0b fault=%0b",
             old_pc, ins, waits, bus.ProgramCounter, bus.RetiredCount, bus.Halted, bus.AddressFault);
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) begin
      randomize_inputs();
      @(negedge Clock);
      check_eq("halt_pc",    bus.ProgramCounter,        m_pc);
      check_eq("halt_ret",   bus.RetiredCount,          m_ret);
      check_eq("halt_flag",  32'(bus.Halted),           32'd1);
      check_eq("halt_valid", 32'(bus.InstructionValid), 32'd0);
      check_eq("halt_fault", 32'(bus.AddressFault),     32'(m_fault));
    end
    $display("halt hold %0d cycles pc=%0d ret=%0d", n, bus.ProgramCounter, bus.RetiredCount);
  endtask

  function automatic logic [31:0] gen_word();
    int          r;
    logic [31:0] w;
    logic [31:0] t;
    r = $urandom_range(0, 99);
    w = $urandom;
    t = (r % 10 < 8) ? 32'($urandom_range(0, DEPTH - 1)) : 32'($urandom_range(DEPTH, 3000));
    if (r < 40) begin
      if (w[31:26] inside {6'h01, 6'h0E, 6'h0D, 6'h10, 6'h11, 6'h0B}) w[31:26] = 6'h20;
    end else if (r < 55) begin
      w = {6'b001110, t[25:0]};
    end else if (r < 62) begin
      w = {6'b001101, w[25:0]};
    end else if (r < 80) begin
      w = {(r < 71) ? 6'b010000 : 6'b010001, w[25:16], t[15:0]};
    end else if (r < 96) begin
      w = {6'b001011, w[25:0]};
    end else begin
      w = {6'b000001, w[25:0]};
    end
    return w;
  endfunction

  function automatic logic [31:0] gen_rv();
    int r;
    r = $urandom_range(0, 99);
    if (r < 90)      return 32'($urandom_range(0, DEPTH - 1));
    else if (r < 95) return 32'd150;
    else             return 32'h8000_0003;
  endfunction

  initial begin
    Reset             = 1'b1;
    bus.BranchTaken   = 1'b0;
    bus.RegisterValue = 32'd0;
    bus.InputReady    = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[1]  = 32'h38000002;  // j 2
    mem[2]  = 32'h34000000;  // jr
    mem[12] = 32'h3800000F;  // j 15
    mem[15] = 32'h4002001B;  // beq 27
    mem[27] = 32'h3800000F;  // j 15
    mem[16] = 32'h38000005;  // j 5
    mem[5]  = 32'h2C000000;  // in
    mem[6]  = 32'h3800001F;  // j 31
    mem[31] = 32'h04000000;  // halt

    do_reset();
    do_instr(1'b0, 32'd0,  1'b0, 0);  // add at 0
    do_instr(1'b0, 32'd0,  1'b0, 0);  // j 2
    do_instr(1'b0, 32'd12, 1'b0, 0);  // jr 12
    do_instr(1'b0, 32'd0,  1'b0, 0);  // j 15
    do_instr(1'b1, 32'd0,  1'b0, 0);  // beq taken -> 27
    do_instr(1'b0, 32'd0,  1'b0, 0);  // j 15
    do_instr(1'b0, 32'd0,  1'b0, 0);  // beq not taken -> 16
    do_instr(1'b0, 32'd0,  1'b0, 0);  // j 5
    do_instr(1'b0, 32'd0,  1'b0, 5);  // in, five wait cycles
    do_instr(1'b0, 32'd0,  1'b0, 0);  // j 31
    do_instr(1'b0, 32'd0,  1'b0, 0);  // halt
    hold_halt(20);

    do_reset();
    mem[0] = 32'h34000000;            // jr out of range
    do_instr(1'b0, 32'd150, 1'b0, 0);
    hold_halt(3);

    do_reset();
    mem[0]  = 32'h38000063;           // j 99
    mem[99] = 32'h00000000;           // sequential off the end
    do_instr(1'b0, 32'd0, 1'b0, 0);
    do_instr(1'b0, 32'd0, 1'b0, 0);
    hold_halt(3);

    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = gen_word();
      do_reset();
      for (int n = 0; n < 50 && !m_halted; n++) begin
        do_instr(1'($urandom_range(0, 1)), gen_rv(), 1'($urandom_range(0, 1)),
                 int'($urandom_range(1, 4)));
      end
      if (m_halted) hold_halt(4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
